// File: rtl/sig_conv_pkg.sv
// Shared types and constants for the BCD-to-signed-binary converter.
package sig_conv_pkg;

    localparam int ACC_W = 10;

    localparam logic [ACC_W-1:0] MAX_POS_MAG = 10'd127;
    localparam logic [ACC_W-1:0] MAX_NEG_MAG = 10'd128;
    localparam logic [3:0]       BCD_MAX     = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        ACC_T,
        ACC_U,
        RESOLVE
    } state_t;

endpackage

// File: rtl/bcd_acc_step.sv
// One decimal accumulation step: acc_out = acc_in*10 + digit, using shifts.
import sig_conv_pkg::*;

module bcd_acc_step (
    input  logic [ACC_W-1:0] acc_in,
    input  logic [3:0]       digit,
    output logic [ACC_W-1:0] acc_out
);

    // Valid inputs never exceed 999, so the 10-bit sum cannot wrap.
    assign acc_out = (acc_in << 3) + (acc_in << 1) + ACC_W'(digit);

endmodule

// File: rtl/sig_3digit_to_8bit.sv
// Three BCD digits plus sign -> 8-bit two's-complement, 3-cycle start/done handshake.
// Optional: define SIG3_TO_8_SAT_EN to saturate on overflow instead of forcing zero.
import sig_conv_pkg::*;

module sig_3digit_to_8bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    input  logic       sign,
    output logic       busy,
    output logic       done,
    output logic [7:0] signed_num,
    output logic       err_digit,
    output logic       overflow
);

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [3:0]       tens_q;
    logic [3:0]       units_q;
    logic             sign_q;
    logic             err_q;
    logic             done_q;
    logic [7:0]       num_q;
    logic             err_digit_q;
    logic             overflow_q;
    logic [3:0]       step_digit;
    logic             mag_too_big;
    logic [7:0]       ovf_value;
    logic [7:0]       norm_value;

    // The same step unit serves both accumulation states; only the digit differs.
    assign step_digit = (state_q == ACC_T) ? tens_q : units_q;

    bcd_acc_step u_step (
        .acc_in  (acc_q),
        .digit   (step_digit),
        .acc_out (acc_d)
    );

    assign mag_too_big = sign_q ? (acc_q > MAX_NEG_MAG) : (acc_q > MAX_POS_MAG);
    // Magnitude 128 negated in 8 bits is 8'h80, which is exactly -128.
    assign norm_value  = sign_q ? 8'(~acc_q[7:0] + 8'd1) : acc_q[7:0];

`ifdef SIG3_TO_8_SAT_EN
    assign ovf_value = sign_q ? 8'h80 : 8'h7F;
`else
    assign ovf_value = 8'h00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            tens_q      <= '0;
            units_q     <= '0;
            sign_q      <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            num_q       <= '0;
            err_digit_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        tens_q  <= tens;
                        units_q <= units;
                        sign_q  <= sign;
                        err_q   <= (hundreds > BCD_MAX) || (tens > BCD_MAX) || (units > BCD_MAX);
                        acc_q   <= ACC_W'(hundreds);
                        state_q <= ACC_T;
                    end
                end
                ACC_T: begin
                    acc_q   <= acc_d;
                    state_q <= ACC_U;
                end
                ACC_U: begin
                    acc_q   <= acc_d;
                    state_q <= RESOLVE;
                end
                RESOLVE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                    if (err_q) begin
                        num_q       <= 8'h00;
                        err_digit_q <= 1'b1;
                        overflow_q  <= 1'b0;
                    end else if (mag_too_big) begin
                        num_q       <= ovf_value;
                        err_digit_q <= 1'b0;
                        overflow_q  <= 1'b1;
                    end else begin
                        num_q       <= norm_value;
                        err_digit_q <= 1'b0;
                        overflow_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign signed_num = num_q;
    assign err_digit  = err_digit_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_sig_3digit_to_8bit.sv
// Scoreboard bench for sig_3digit_to_8bit; honours SIG3_TO_8_SAT_EN for expected overflow values.
module tb_sig_3digit_to_8bit;

    typedef struct packed {
        logic [7:0] num;
        logic       err;
        logic       ovf;
    } exp_t;

`ifdef SIG3_TO_8_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [3:0] hundreds = '0;
    logic [3:0] tens = '0;
    logic [3:0] units = '0;
    logic       sign = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] signed_num;
    logic       err_digit;
    logic       overflow;

    int   checks = 0;
    int   failures = 0;
    int   txn = 0;
    exp_t exp_q[$];

    sig_3digit_to_8bit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .hundreds   (hundreds),
        .tens       (tens),
        .units      (units),
        .sign       (sign),
        .busy       (busy),
        .done       (done),
        .signed_num (signed_num),
        .err_digit  (err_digit),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] n, input logic e, input logic o);
        exp_t r;
        r.num = n;
        r.err = e;
        r.ovf = o;
        return r;
    endfunction

    // Monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 (no conversion pending)");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                txn++;
                check("signed_num", 32'(signed_num), 32'(e.num));
                check("err_digit", 32'(err_digit), 32'(e.err));
                check("overflow", 32'(overflow), 32'(e.ovf));
                $display("txn %0d: signed_num=%02h err_digit=%0b overflow=%0b (exp %02h %0b %0b)",
                         txn, signed_num, err_digit, overflow, e.num, e.err, e.ovf);
            end
        end
    end

    // Issue one conversion, scramble inputs during busy, and check handshake timing.
    task automatic convert(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u,
                           input logic s, input exp_t e, input string tag);
        exp_q.push_back(e);
        hundreds = h; tens = t; units = u; sign = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hundreds = 4'h9; tens = 4'h0; units = 4'h1; sign = ~s;
        for (int i = 0; i < 3; i++) begin
            check({tag, "_busy_phase"}, 32'({busy, done}), 32'b10);
            @(posedge clk); #1;
        end
        check({tag, "_done_latency"}, 32'({busy, done}), 32'b01);
        @(posedge clk); #1;
        check({tag, "_done_pulse_end"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_num", 32'(signed_num), 32'd0);
        check("reset_err", 32'(err_digit), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        convert(4'd1, 4'd2, 4'd7, 1'b0, mk(8'h7F, 1'b0, 1'b0), "p127");
        convert(4'd1, 4'd2, 4'd8, 1'b1, mk(8'h80, 1'b0, 1'b0), "n128");
        convert(4'd1, 4'd2, 4'd8, 1'b0, mk(SAT ? 8'h7F : 8'h00, 1'b0, 1'b1), "p128_ovf");
        convert(4'd9, 4'd9, 4'd9, 1'b1, mk(SAT ? 8'h80 : 8'h00, 1'b0, 1'b1), "n999_ovf");
        convert(4'd0, 4'd0, 4'd0, 1'b1, mk(8'h00, 1'b0, 1'b0), "neg_zero");
        convert(4'd0, 4'd0, 4'd5, 1'b1, mk(8'hFB, 1'b0, 1'b0), "n5");
        convert(4'd2, 4'd5, 4'd5, 1'b0, mk(SAT ? 8'h7F : 8'h00, 1'b0, 1'b1), "p255_ovf");
        convert(4'd0, 4'hA, 4'd3, 1'b0, mk(8'h00, 1'b1, 1'b0), "bad_tens");
        repeat (2) @(posedge clk); #1;
        check("err_hold", 32'({err_digit, overflow, signed_num}), 32'h200);

        // start held high: one conversion every 4 cycles.
        for (int n = 0; n < 3; n++) exp_q.push_back(mk(8'hD6, 1'b0, 1'b0));
        hundreds = 4'd0; tens = 4'd4; units = 4'd2; sign = 1'b1; start = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            check("b2b_busy", 32'(busy), 32'd1);
            repeat (3) @(posedge clk);
            #1;
            check("b2b_done", 32'(done), 32'd1);
        end
        start = 1'b0;
        @(posedge clk); #1;

        // Async reset during ACC_U aborts the conversion with no done pulse.
        hundreds = 4'd0; tens = 4'd5; units = 4'd5; sign = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_num", 32'(signed_num), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        convert(4'd0, 4'd9, 4'd9, 1'b0, mk(8'h63, 1'b0, 1'b0), "after_abort");

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
